// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC, single-outstanding imem req/ack, small fetch FIFO.
// Define IF_FETCH_PERF_EN to add bubble_cnt_o, a saturating count of valid_o=0 cycles.
module if_fetch_unit #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] PC_STEP    = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    output logic [31:0] add_pc_o,
`ifdef IF_FETCH_PERF_EN
    output logic [31:0] bubble_cnt_o,
`endif
    output logic [31:0] instruction_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       req_addr_q, req_addr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [31:0]       mem_pc_q [FIFO_DEPTH];
    logic [31:0]       mem_pc_d [FIFO_DEPTH];
    logic [31:0]       mem_instr_q [FIFO_DEPTH];
    logic [31:0]       mem_instr_d [FIFO_DEPTH];

    logic        push, pop, space;
    logic [31:0] pc_inc;

    assign pc_inc = pc_q + PC_STEP;
    assign pop    = valid_o & ~stall_i & ~redirect_i;
    // A redirect in the same cycle as an ack drops the returned word.
    assign push   = (state_q == StWait) & imem_ack_i & ~redirect_i;

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_pc_d    = mem_pc_q;
        mem_instr_d = mem_instr_q;
        if (redirect_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d = count_q + CntW'(push) - CntW'(pop);
            if (push) begin
                mem_pc_d[wr_ptr_q]    = pc_inc;
                mem_instr_d[wr_ptr_q] = imem_data_i;
                wr_ptr_d              = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
        end
    end

    // Issue only when the FIFO still has room after this cycle's push/pop.
    assign space = count_d < CntW'(FIFO_DEPTH);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        case (state_q)
            StIdle: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                end else if (space) begin
                    state_d    = StWait;
                    req_addr_d = pc_q;
                end
            end
            StWait: begin
                if (imem_ack_i) begin
                    if (redirect_i) begin
                        pc_d    = redirect_pc_i;
                        state_d = StIdle;
                    end else begin
                        pc_d = pc_inc;
                        if (space) begin
                            req_addr_d = pc_inc;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end else if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                end
                if (imem_ack_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            req_addr_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_pc_q    <= '{default: '0};
            mem_instr_q <= '{default: '0};
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_pc_q    <= mem_pc_d;
            mem_instr_q <= mem_instr_d;
        end
    end

    assign imem_req_o    = (state_q != StIdle);
    assign imem_addr_o   = req_addr_q;
    assign valid_o       = (count_q != '0);
    assign add_pc_o      = valid_o ? mem_pc_q[rd_ptr_q] : '0;
    assign instruction_o = valid_o ? mem_instr_q[rd_ptr_q] : '0;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] bubble_q, bubble_d;

    always_comb begin
        bubble_d = bubble_q;
        if (!valid_o && (bubble_q != '1)) begin
            bubble_d = bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bubble_q <= '0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

    assign bubble_cnt_o = bubble_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: random stall/redirect/ack-delay stimulus, and a
// reference model that predicts the in-order instruction stream from each reset/redirect PC.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] STEP     = 32'd4;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        valid_o;
    logic [31:0] add_pc_o;
    logic [31:0] instruction_o;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] bubble_cnt_o;
`endif

    if_fetch_unit #(
        .FIFO_DEPTH (2),
        .RESET_PC   (RESET_PC),
        .PC_STEP    (STEP)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .add_pc_o      (add_pc_o),
`ifdef IF_FETCH_PERF_EN
        .bubble_cnt_o  (bubble_cnt_o),
`endif
        .instruction_o (instruction_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input bit ok, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    // ---------------- reference model + monitor ----------------
    logic [63:0] exp_q[$];
    logic [31:0] next_pc   = RESET_PC;
    bit          pend_req  = 1'b1;
    logic [31:0] pend_addr = RESET_PC;
    bit          prev_req, prev_ack, prev_redir;
    logic [31:0] prev_addr;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] exp_bub = '0;
`endif

    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            exp_q.delete();
            next_pc    = RESET_PC;
            pend_req   = 1'b1;
            pend_addr  = RESET_PC;
            prev_req   = 1'b0;
            prev_ack   = 1'b0;
            prev_redir = 1'b0;
`ifdef IF_FETCH_PERF_EN
            exp_bub = '0;
`endif
        end else begin
            while (exp_q.size() < 4) begin
                logic [31:0] nxt;
                nxt = next_pc + STEP;
                exp_q.push_back({nxt, mem_word(next_pc)});
                next_pc = nxt;
            end
            if (prev_redir)
                chk("flush_empty", !valid_o, {63'b0, valid_o}, 64'd0);
            if (!valid_o) begin
                chk("nop_when_empty", (add_pc_o == '0) && (instruction_o == '0),
                    {add_pc_o, instruction_o}, 64'd0);
            end else begin
                chk("head", {add_pc_o, instruction_o} == exp_q[0],
                    {add_pc_o, instruction_o}, exp_q[0]);
                if (!stall_i && !redirect_i) void'(exp_q.pop_front());
            end
            if (prev_req && !prev_ack)
                chk("req_hold", imem_req_o && (imem_addr_o == prev_addr),
                    {31'b0, imem_req_o, imem_addr_o}, {32'd1, prev_addr});
            if (imem_req_o && (!prev_req || prev_ack) && pend_req) begin
                chk("new_req_addr", imem_addr_o == pend_addr, {32'd0, imem_addr_o},
                    {32'd0, pend_addr});
                pend_req = 1'b0;
            end
`ifdef IF_FETCH_PERF_EN
            chk("bubble_cnt", bubble_cnt_o == exp_bub, {32'd0, bubble_cnt_o}, {32'd0, exp_bub});
            if (!valid_o) exp_bub++;
`endif
            if (redirect_i) begin
                exp_q.delete();
                next_pc   = redirect_pc_i;
                pend_req  = 1'b1;
                pend_addr = redirect_pc_i;
            end
            prev_req   = imem_req_o;
            prev_ack   = imem_ack_i;
            prev_addr  = imem_addr_o;
            prev_redir = redirect_i;
        end
    end

    // ---------------- stimulus ----------------
    int unsigned ack_pct      = 100;
    bit          ack_if_empty = 1'b0;

    task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
        bit a;
        @(posedge clk_i);
        #1;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rd ? rpc : $urandom;
        if (ack_if_empty) a = imem_req_o && !valid_o;
        else a = imem_req_o && ($urandom_range(0, 99) < ack_pct);
        imem_ack_i  = a;
        imem_data_i = a ? mem_word(imem_addr_o) : $urandom;
    endtask

    initial begin
        int cnt;
        bit found;
        logic [31:0] rpc;

        repeat (3) @(posedge clk_i);
        #2;
        chk("reset_outs", !imem_req_o && imem_addr_o == '0 && !valid_o && add_pc_o == '0 &&
            instruction_o == '0, {imem_req_o, imem_addr_o, valid_o, 30'd0}, 64'd0);
        rst_n_i = 1'b1;

        // Latency and back-to-back throughput with single-cycle ack.
        ack_pct = 100;
        step(0, 0, 0);
        chk("latency_c1", !valid_o, {63'b0, valid_o}, 64'd0);
        step(0, 0, 0);
        chk("latency_c2", valid_o, {63'b0, valid_o}, 64'd1);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0);
            if (valid_o) cnt++;
        end
        chk("throughput", cnt == 10, 64'(cnt), 64'd10);

        // Stall fills the FIFO and throttles requests.
        for (int i = 0; i < 6; i++) step(1, 0, 0);
        chk("stall_req_drop", !imem_req_o && valid_o, {62'b0, imem_req_o, valid_o}, 64'd1);
        ack_pct = 0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0);
            if (valid_o) cnt++;
        end
        chk("stall_depth", cnt == 2, 64'(cnt), 64'd2);

        // Redirect while a request is outstanding without ack.
        chk("pre_redir_wait", imem_req_o, {63'b0, imem_req_o}, 64'd1);
        step(0, 1, 32'h100);
        ack_pct = 100;
        for (int i = 0; i < 8; i++) step(0, 0, 0);

        // Redirect in the same cycle as an ack.
        step(0, 1, 32'h2000);
        chk("redir_ack_setup", imem_req_o && imem_ack_i, {62'b0, imem_req_o, imem_ack_i}, 64'd3);
        for (int i = 0; i < 8; i++) step(0, 0, 0);

        // Randomized traffic, including PCs near the 2^32 wrap.
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) ack_pct = $urandom_range(30, 100);
            rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, rpc);
        end

        // Async reset while WAIT with one buffered entry.
        ack_if_empty = 1'b1;
        step(1, 1, 32'h3000);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 0, 0);
            found = valid_o && imem_req_o && !imem_ack_i;
        end
        chk("reach_wait_one", found, {63'b0, found}, 64'd1);
        #1;
        rst_n_i = 1'b0;
        #1;
        chk("async_reset_outs", !imem_req_o && imem_addr_o == '0 && !valid_o && add_pc_o == '0 &&
            instruction_o == '0, {imem_req_o, imem_addr_o, valid_o, 30'd0}, 64'd0);
        ack_if_empty = 1'b0;
        imem_ack_i   = 1'b0;
        stall_i      = 1'b0;
        redirect_i   = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        rst_n_i     = 1'b1;
        imem_ack_i  = 1'b1;  // stray ack while idle must be ignored
        imem_data_i = 32'hDEAD_BEEF;
        ack_pct     = 100;
        for (int i = 0; i < 30; i++) step($urandom_range(0, 4) == 0, 0, 0);

        repeat (3) @(posedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

endmodule
